bandai_mapper_cfg: RTL and testbench
====================================

Name: bandai_mapper_cfg

Overview:
- Bus-master sequencer that configures the Bandai 2003 cartridge mapper from a host: a flash dumper or test fixture standing in for the console.
- Drives the mapper's console-side bus (ADDR, DQ, CEn, WEn, OEn, SSn). Performs the 5Ah/A5h unlock, checks the 18-bit SO sync stream, then writes the four bank registers C0h–C3h.
- Host interface is a start/busy/done/err handshake.

Parameters:
WR_LOW_CYC, 2, CLK cycles WEn is held low per register write (min 1)
RD_WAIT_CYC, 2, CLK cycles OEn is held low before sampling DQ on readback (min 1)

Ports:
CLK  in  1  system clock; mapper CLK shares it
RSTn  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; ignored while busy=1
cfg_lao  in  8  value for register C0h (linear address offset)
cfg_bram  in  8  value for register C1h (RAM bank)
cfg_brom0  in  8  value for register C2h (ROM bank 0)
cfg_brom1  in  8  value for register C3h (ROM bank 1)
busy  out  1  sequence in progress
done  out  1  high from sequence success until next accepted start
err  out  1  high from failure until next accepted start
unlocked  out  1  mapper unlock completed since reset
m_addr  out  8  mapper ADDR bus
m_dq_o  out  8  write data to mapper DQ
m_dq_oe  out  1  enables m_dq_o onto DQ
m_dq_i  in  8  DQ as seen from the bus
m_cen, m_wen, m_oen, m_ssn  out  1 each  mapper strobes, active-low
m_so  in  1  mapper SO

Behaviour:
- Reset and idle values (async on RSTn and in IDLE/DONE/ERR): m_addr=00h, m_dq_oe=0, m_dq_o=00h, m_cen=m_wen=m_oen=m_ssn=1.
- Reset values of status outputs: busy=done=err=unlocked=0.
- A reset mid-sequence returns all outputs to these values immediately. No partial write completes: WEn rises only from the async reset. Because the mapper shares RSTn, both sides restart locked.
- Start acceptance: start with busy=0 latches all cfg_* inputs, clears done/err, sets busy on the next edge.
  - unlocked=0: go to UNLK_A.
  - unlocked=1: go to WR_SETUP with index=0.
- UNLK_A: m_addr=5Ah for exactly one cycle, strobes idle.
- UNLK_B: m_addr=A5h for exactly one cycle.
- SYNC:
  - m_addr=00h. Sample m_so on 18 consecutive edges, starting with the first edge after the UNLK_B edge.
  - Compare LSB-first against SYNC_PAT = {1'b0, 16'h28A0, 1'b0}; sample k is checked against SYNC_PAT[k].
  - First mismatch: go to ERR.
  - All 18 match: set unlocked=1, go to WR_SETUP with index=0.
- Write sequence, per register i = 0..3:
  - WR_SETUP (1 cycle): m_addr=C0h+i, m_dq_o=value, m_dq_oe=1, m_cen=0, m_ssn=1, m_wen=1, m_oen=1.
  - WR_LOW (WR_LOW_CYC cycles): m_wen=0, everything else held.
  - WR_HOLD (1 cycle): m_wen=1, address and data held. This rising WEn is the mapper's latch edge.
  - WR_IDLE (1 cycle): bus returns to idle values.
  - If i<3, increment i and go to WR_SETUP; otherwise go to readback (CFG_READBACK_EN) or DONE.
- Total cycles per write = 3 + WR_LOW_CYC.
- DONE/ERR:
  - busy=0; done or err set on the same edge busy falls; held until next accepted start.
  - done and err are never both 1.
- Glitch-free strobes: m_wen, m_oen, m_cen, m_dq_oe driven directly from registers, no combinational decode.
- DQ is never driven by this block while m_oen=0.
- Bus contention: m_dq_oe=0 at least one full cycle before and after any cycle with m_oen=0.

Optional Feature:
- Macro: CFG_READBACK_EN
- Defined: after the write of C3h, for each i = 0..3:
  - RB_SETUP (1 cycle): m_addr=C0h+i, m_cen=0, m_ssn=1, m_wen=1, m_dq_oe=0.
  - RB_WAIT (RD_WAIT_CYC cycles): m_oen=0; m_dq_i sampled on the last edge.
  - RB_IDLE (1 cycle): bus idle.
  - Sample ≠ latched value: go to ERR. All four match: go to DONE.
- Undefined: RB states absent; go from the last WR_IDLE to DONE. RD_WAIT_CYC is unused.

Decomposition:
- Package bandai_mapper_pkg holds:
  - ADDR_UNLK_A=5Ah, ADDR_UNLK_B=A5h, ADDR_LAO=C0h, ADDR_BRAM=C1h, ADDR_BROM0=C2h, ADDR_BROM1=C3h
  - SYNC_PAT (18 bits), SYNC_LEN=18
  - state enum typedef
- Sub-module bandai_so_checker: 5-bit bit counter plus comparator. Inputs arm/m_so; outputs match_ok/mismatch, each a one-cycle pulse.

Test Plan:
1. Reset, then start with cfg = 12h/34h/56h/78h against the mapper model → unlock, 18-bit sync pass, writes complete. done=1, unlocked=1, mapper bank regs = 12h/34h/56h/78h.
2. With unlocked=1, start with cfg = 00h/01h/02h/03h → no 5Ah/A5h cycles on m_addr. Exactly 4×(3+WR_LOW_CYC) busy cycles; regs updated.
3. Model SO stuck at 1 → err=1 on the sync edge for bit 0; unlocked=0; no WEn low pulse ever issued.
4. Assert RSTn low during WR_LOW of register C2h → all outputs at idle values that cycle. After release, busy=0, unlocked=0, mapper regs = FFh.
5. start pulsed while busy=1, with different cfg → ignored; final regs equal the first cfg.
6. CFG_READBACK_EN defined, model forces bit 0 of C1h readback low with cfg_bram=FFh → err=1, done=0. With the fault removed, done=1.

Source files
------------

// File: rtl/bandai_mapper_pkg.sv
// bandai_mapper_pkg: bus addresses, sync pattern and sequencer states for the Bandai 2003 mapper configurator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bandai_mapper_pkg;

    localparam logic [7:0] ADDR_UNLK_A = 8'h5A;
    localparam logic [7:0] ADDR_UNLK_B = 8'hA5;
    localparam logic [7:0] ADDR_LAO    = 8'hC0;
    localparam logic [7:0] ADDR_BRAM   = 8'hC1;
    localparam logic [7:0] ADDR_BROM0  = 8'hC2;
    localparam logic [7:0] ADDR_BROM1  = 8'hC3;

    // SO stream the mapper emits after a successful unlock, checked LSB first.
    localparam int                   SYNC_LEN = 18;
    localparam logic [SYNC_LEN-1:0]  SYNC_PAT = {1'b0, 16'h28A0, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNLK_A,
        S_UNLK_B,
        S_SYNC,
        S_WR_SETUP,
        S_WR_LOW,
        S_WR_HOLD,
        S_WR_IDLE,
`ifdef CFG_READBACK_EN
        S_RB_SETUP,
        S_RB_WAIT,
        S_RB_IDLE,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // Bank register address for register index 0..3 (C0h..C3h).
    function automatic logic [7:0] reg_addr(input logic [1:0] idx);
        return ADDR_LAO + {6'd0, idx};
    endfunction

endpackage

// File: rtl/bandai_so_checker.sv
// bandai_so_checker: compares the mapper SO stream LSB-first against SYNC_PAT while armed.
// Latency: verdict is combinational for the bit sampled on the coming edge; counter advances per armed cycle.
// Backpressure: none; dropping arm clears the bit counter.
module bandai_so_checker
    import bandai_mapper_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    input  logic arm,
    input  logic m_so,
    output logic match_ok,
    output logic mismatch
);

    logic [4:0] bit_cnt_q;
    logic [4:0] bit_cnt_d;
    logic       exp_bit;
    logic       last_bit;

    // Verdict for the bit sampled on the coming edge, and the next bit index.
    always_comb begin
        exp_bit   = SYNC_PAT[bit_cnt_q];
        last_bit  = (bit_cnt_q == 5'(SYNC_LEN - 1));
        mismatch  = arm && (m_so != exp_bit);
        match_ok  = arm && (m_so == exp_bit) && last_bit;
        bit_cnt_d = 5'd0;
        if (arm && !last_bit) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
        end
    end

    // Bit counter register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bit_cnt_q <= 5'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/bandai_mapper_cfg.sv
// bandai_mapper_cfg: unlocks the Bandai 2003 mapper, checks its SO sync and writes bank registers C0h-C3h (readback under CFG_READBACK_EN).
// Latency: 4*(3+WR_LOW_CYC) busy cycles when already unlocked, 20 more for unlock+sync, plus 4*(2+RD_WAIT_CYC) with readback.
// Backpressure: start is ignored while busy; done/err hold until the next accepted start.
module bandai_mapper_cfg
    import bandai_mapper_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int RD_WAIT_CYC = 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       start,
    input  logic [7:0] cfg_lao,
    input  logic [7:0] cfg_bram,
    input  logic [7:0] cfg_brom0,
    input  logic [7:0] cfg_brom1,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       unlocked,
    output logic [7:0] m_addr,
    output logic [7:0] m_dq_o,
    output logic       m_dq_oe,
    input  logic [7:0] m_dq_i,
    output logic       m_cen,
    output logic       m_wen,
    output logic       m_oen,
    output logic       m_ssn,
    input  logic       m_so
);

    // One shared wait counter covers both the WEn-low and the OEn-low phases.
    localparam int MAX_WAIT = (WR_LOW_CYC > RD_WAIT_CYC) ? WR_LOW_CYC : RD_WAIT_CYC;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0][7:0]       cfg_q, cfg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  unlocked_q, unlocked_d;

    logic [7:0]            m_addr_q, m_addr_d;
    logic [7:0]            m_dq_o_q, m_dq_o_d;
    logic                  m_dq_oe_q, m_dq_oe_d;
    logic                  m_cen_q, m_cen_d;
    logic                  m_wen_q, m_wen_d;
    logic                  m_oen_q, m_oen_d;
    logic                  m_ssn_q, m_ssn_d;

    logic                  so_arm;
    logic                  so_match;
    logic                  so_mismatch;

    assign so_arm = (state_q == S_SYNC);

    bandai_so_checker u_so_checker (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .arm      (so_arm),
        .m_so     (m_so),
        .match_ok (so_match),
        .mismatch (so_mismatch)
    );

`ifndef CFG_READBACK_EN
    // DQ input only matters when registers are read back.
    logic unused_dq_i;
    assign unused_dq_i = ^m_dq_i;
`endif

    // Next-state and status logic for the unlock / sync / write (/ readback) sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cfg_d      = cfg_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        unlocked_d = unlocked_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    cfg_d   = {cfg_brom1, cfg_brom0, cfg_bram, cfg_lao};
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = unlocked_q ? S_WR_SETUP : S_UNLK_A;
                end
            end
            S_UNLK_A: state_d = S_UNLK_B;
            S_UNLK_B: state_d = S_SYNC;
            S_SYNC: begin
                if (so_mismatch) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (so_match) begin
                    unlocked_d = 1'b1;
                    idx_d      = 2'd0;
                    state_d    = S_WR_SETUP;
                end
            end
            S_WR_SETUP: begin
                cnt_d   = '0;
                state_d = S_WR_LOW;
            end
            S_WR_LOW: begin
                if (cnt_q == CNT_W'(WR_LOW_CYC - 1)) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_HOLD: state_d = S_WR_IDLE;
            S_WR_IDLE: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_WR_SETUP;
                end else begin
`ifdef CFG_READBACK_EN
                    idx_d   = 2'd0;
                    state_d = S_RB_SETUP;
`else
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CFG_READBACK_EN
            S_RB_SETUP: begin
                cnt_d   = '0;
                state_d = S_RB_WAIT;
            end
            S_RB_WAIT: begin
                if (cnt_q == CNT_W'(RD_WAIT_CYC - 1)) begin
                    if (m_dq_i != cfg_q[idx_q]) begin
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_RB_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RB_IDLE: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_RB_SETUP;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Bus values for the state being entered, so every strobe comes straight off a flop.
    always_comb begin
        m_addr_d  = 8'h00;
        m_dq_o_d  = 8'h00;
        m_dq_oe_d = 1'b0;
        m_cen_d   = 1'b1;
        m_wen_d   = 1'b1;
        m_oen_d   = 1'b1;
        m_ssn_d   = 1'b1;
        case (state_d)
            S_UNLK_A: m_addr_d = ADDR_UNLK_A;
            S_UNLK_B: m_addr_d = ADDR_UNLK_B;
            S_WR_SETUP, S_WR_LOW, S_WR_HOLD: begin
                m_addr_d  = reg_addr(idx_d);
                m_dq_o_d  = cfg_d[idx_d];
                m_dq_oe_d = 1'b1;
                m_cen_d   = 1'b0;
                m_wen_d   = (state_d != S_WR_LOW);
            end
`ifdef CFG_READBACK_EN
            S_RB_SETUP, S_RB_WAIT: begin
                m_addr_d = reg_addr(idx_d);
                m_cen_d  = 1'b0;
                m_oen_d  = (state_d != S_RB_WAIT);
            end
`endif
            default: ;
        endcase
    end

    // State, status and bus registers; async reset forces the idle bus immediately.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            unlocked_q <= 1'b0;
            m_addr_q   <= 8'h00;
            m_dq_o_q   <= 8'h00;
            m_dq_oe_q  <= 1'b0;
            m_cen_q    <= 1'b1;
            m_wen_q    <= 1'b1;
            m_oen_q    <= 1'b1;
            m_ssn_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            unlocked_q <= unlocked_d;
            m_addr_q   <= m_addr_d;
            m_dq_o_q   <= m_dq_o_d;
            m_dq_oe_q  <= m_dq_oe_d;
            m_cen_q    <= m_cen_d;
            m_wen_q    <= m_wen_d;
            m_oen_q    <= m_oen_d;
            m_ssn_q    <= m_ssn_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign unlocked = unlocked_q;
    assign m_addr   = m_addr_q;
    assign m_dq_o   = m_dq_o_q;
    assign m_dq_oe  = m_dq_oe_q;
    assign m_cen    = m_cen_q;
    assign m_wen    = m_wen_q;
    assign m_oen    = m_oen_q;
    assign m_ssn    = m_ssn_q;

endmodule

// File: tb/tb_bandai_mapper_cfg.sv
// tb_bandai_mapper_cfg: drives bandai_mapper_cfg against a behavioural Bandai 2003 mapper model.
// Expected results are queued at each start and checked by a monitor when busy falls.
// Bus-protocol rules (contention, done/err exclusivity, SSn) are watched every cycle.
`timescale 1ns/1ps
module tb_bandai_mapper_cfg;

    localparam int WR_LOW_CYC  = 2;
    localparam int RD_WAIT_CYC = 2;
    localparam int WR_CYC      = 3 + WR_LOW_CYC;
`ifdef CFG_READBACK_EN
    localparam int RB_CYC      = 4 * (2 + RD_WAIT_CYC);
`else
    localparam int RB_CYC      = 0;
`endif
    localparam logic [31:0] IDLE_VEC = 32'h0000_00F0;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       start;
    logic [7:0] cfg_lao, cfg_bram, cfg_brom0, cfg_brom1;
    logic       busy, done, err, unlocked;
    logic [7:0] m_addr, m_dq_o, m_dq_i;
    logic       m_dq_oe, m_cen, m_wen, m_oen, m_ssn, m_so;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    bandai_mapper_cfg #(
        .WR_LOW_CYC  (WR_LOW_CYC),
        .RD_WAIT_CYC (RD_WAIT_CYC)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start     (start),
        .cfg_lao   (cfg_lao),
        .cfg_bram  (cfg_bram),
        .cfg_brom0 (cfg_brom0),
        .cfg_brom1 (cfg_brom1),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .unlocked  (unlocked),
        .m_addr    (m_addr),
        .m_dq_o    (m_dq_o),
        .m_dq_oe   (m_dq_oe),
        .m_dq_i    (m_dq_i),
        .m_cen     (m_cen),
        .m_wen     (m_wen),
        .m_oen     (m_oen),
        .m_ssn     (m_ssn),
        .m_so      (m_so)
    );

    // ---------------- mapper model ----------------
    logic [17:0]     sync_v = 18'h05140;
    logic [3:0][7:0] mreg;
    logic            m_unl, prev5a, so_act, wen_prev;
    logic [4:0]      so_idx;
    logic            so_stuck = 1'b0;
    logic            rb_fault = 1'b0;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mreg     <= {4{8'hFF}};
            m_unl    <= 1'b0;
            prev5a   <= 1'b0;
            so_act   <= 1'b0;
            so_idx   <= 5'd0;
            wen_prev <= 1'b1;
        end else begin
            prev5a   <= (m_addr == 8'h5A);
            wen_prev <= m_wen;
            if (prev5a && m_addr == 8'hA5) begin
                so_act <= 1'b1;
                so_idx <= 5'd0;
            end else if (so_act) begin
                if (so_idx == 5'd17) begin
                    so_act <= 1'b0;
                    m_unl  <= 1'b1;
                end
                so_idx <= so_idx + 5'd1;
            end
            if (m_unl && !wen_prev && m_wen && !m_cen && m_dq_oe && m_addr[7:2] == 6'h30)
                mreg[m_addr[1:0]] <= m_dq_o;
        end
    end

    assign m_so   = so_stuck ? 1'b1 : (so_act ? sync_v[so_idx] : 1'b1);
    assign m_dq_i = (!m_oen && !m_cen && m_addr[7:2] == 6'h30)
                  ? (mreg[m_addr[1:0]] & ((rb_fault && m_addr == 8'hC1) ? 8'hFE : 8'hFF))
                  : 8'h00;

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bus_vec();
        return {7'd0, m_addr, m_dq_o, m_dq_oe, m_cen, m_wen, m_oen, m_ssn, busy, done, err, unlocked};
    endfunction

    typedef struct {
        logic        done;
        logic        err;
        logic        unl;
        logic [31:0] regs;
        int          busy_cyc;
        int          unlk_cyc;
        int          wen_low;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    task automatic push_exp(input logic d, input logic e, input logic u, input logic [31:0] r,
                            input int bc, input int uc, input int wl);
        exp_t x;
        x.done = d; x.err = e; x.unl = u; x.regs = r;
        x.busy_cyc = bc; x.unlk_cyc = uc; x.wen_low = wl;
        exp_q.push_back(x);
    endtask

    int   mon_busy = 0, mon_unlk = 0, mon_wen = 0;
    logic busy_prev = 1'b0, oen_prev = 1'b1, oe_prev = 1'b0;

    // Monitor: protocol rules every cycle, scoreboard pop whenever a sequence ends.
    always @(negedge CLK) begin
        if (!RSTn) begin
            busy_prev = 1'b0; oen_prev = 1'b1; oe_prev = 1'b0;
            mon_busy = 0; mon_unlk = 0; mon_wen = 0;
        end else begin
            if (!m_oen && (m_dq_oe || oe_prev)) begin
                n_bad++; $display("FAIL contention_before: oen=%b dq_oe=%b prev_dq_oe=%b, required dq_oe=0", m_oen, m_dq_oe, oe_prev);
            end
            if (!oen_prev && m_dq_oe) begin
                n_bad++; $display("FAIL contention_after: dq_oe=%b one cycle after oen low, required 0", m_dq_oe);
            end
            if (done && err) begin
                n_bad++; $display("FAIL done_err_exclusive: done=%b err=%b, required not both", done, err);
            end
            if (!m_ssn) begin
                n_bad++; $display("FAIL ssn_idle: m_ssn=%b, required 1", m_ssn);
            end
            if (busy) begin
                mon_busy++;
                if (m_addr == 8'h5A || m_addr == 8'hA5) mon_unlk++;
                if (!m_wen) mon_wen++;
            end
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_completion: done=%b err=%b with empty scoreboard, required none", done, err);
                end else begin
                    cur = exp_q.pop_front();
                    check("sb_done",      {31'd0, done},     {31'd0, cur.done});
                    check("sb_err",       {31'd0, err},      {31'd0, cur.err});
                    check("sb_unlocked",  {31'd0, unlocked}, {31'd0, cur.unl});
                    check("sb_regs",      mreg,              cur.regs);
                    check("sb_busy_cyc",  mon_busy,          cur.busy_cyc);
                    check("sb_unlk_cyc",  mon_unlk,          cur.unlk_cyc);
                    check("sb_wen_low",   mon_wen,           cur.wen_low);
                end
                mon_busy = 0; mon_unlk = 0; mon_wen = 0;
            end
            busy_prev = busy;
            oen_prev  = m_oen;
            oe_prev   = m_dq_oe;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        @(posedge CLK); #1;
        cfg_lao = a; cfg_bram = b; cfg_brom0 = c; cfg_brom1 = d;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cfg_lao = ~a; cfg_bram = ~b; cfg_brom0 = ~c; cfg_brom1 = ~d;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < 500);
        if (busy) check(nm, {31'd0, busy}, 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = 1'b0;
        cfg_lao = 8'h00; cfg_bram = 8'h00; cfg_brom0 = 8'h00; cfg_brom1 = 8'h00;

        // Reset values, during and after reset.
        repeat (3) @(negedge CLK);
        check("reset_outputs", bus_vec(), IDLE_VEC);
        #2 RSTn = 1'b1;
        @(negedge CLK);
        check("idle_after_reset", bus_vec(), IDLE_VEC);

        // Unlock, sync, write 12/34/56/78.
        push_exp(1'b1, 1'b0, 1'b1, 32'h7856_3412, 20 + 4*WR_CYC + RB_CYC, 2, 4*WR_LOW_CYC);
        do_start(8'h12, 8'h34, 8'h56, 8'h78);
        wait_idle("t1_timeout");

        // Already unlocked: writes only.
        push_exp(1'b1, 1'b0, 1'b1, 32'h0302_0100, 4*WR_CYC + RB_CYC, 0, 4*WR_LOW_CYC);
        do_start(8'h00, 8'h01, 8'h02, 8'h03);
        wait_idle("t2_timeout");

        // Start pulsed while busy with other values must be ignored.
        push_exp(1'b1, 1'b0, 1'b1, 32'hF0DE_BC9A, 4*WR_CYC + RB_CYC, 0, 4*WR_LOW_CYC);
        do_start(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        repeat (3) @(posedge CLK);
        #1;
        cfg_lao = 8'h11; cfg_bram = 8'h22; cfg_brom0 = 8'h33; cfg_brom1 = 8'h44;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_idle("t5_timeout");

        // Reset during WEn-low of C2h.
        do_start(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(m_addr == 8'hC2 && !m_wen) && n < 200);
        check("t4_reached_c2_wen_low", {24'd0, m_addr}, 32'h0000_00C2);
        #2 RSTn = 1'b0;
        #1 check("t4_reset_mid_write", bus_vec(), IDLE_VEC);
        repeat (2) @(negedge CLK);
        #2 RSTn = 1'b1;
        @(negedge CLK);
        check("t4_status_after_reset", {28'd0, busy, done, err, unlocked}, 32'd0);
        check("t4_mapper_regs", mreg, 32'hFFFF_FFFF);

        // SO stuck at 1: fails on sync bit 0, no write issued.
        so_stuck = 1'b1;
        push_exp(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 3, 2, 0);
        do_start(8'h21, 8'h43, 8'h65, 8'h87);
        wait_idle("t3_timeout");
        so_stuck = 1'b0;

        // Unlock again from locked state.
        push_exp(1'b1, 1'b0, 1'b1, 32'hDF9B_5713, 20 + 4*WR_CYC + RB_CYC, 2, 4*WR_LOW_CYC);
        do_start(8'h13, 8'h57, 8'h9B, 8'hDF);
        wait_idle("t1b_timeout");

`ifdef CFG_READBACK_EN
        // Readback fault on C1h bit 0, then clean readback.
        rb_fault = 1'b1;
        push_exp(1'b0, 1'b1, 1'b1, 32'h0302_FF01, 4*WR_CYC + (2 + RD_WAIT_CYC) + (1 + RD_WAIT_CYC), 0, 4*WR_LOW_CYC);
        do_start(8'h01, 8'hFF, 8'h02, 8'h03);
        wait_idle("t6a_timeout");
        rb_fault = 1'b0;
        push_exp(1'b1, 1'b0, 1'b1, 32'h0302_FF01, 4*WR_CYC + RB_CYC, 0, 4*WR_LOW_CYC);
        do_start(8'h01, 8'hFF, 8'h02, 8'h03);
        wait_idle("t6b_timeout");
`endif

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
